// File: rtl/cla_adder_pipelined.sv
// Pipelined carry-lookahead add/subtract unit with a valid/ready handshake.
// A capture stage folds subtraction into the operands (B' = ~B, carry-in = 1).
// STAGES carry stages follow, and each one resolves an equal slice of 4-bit blocks.
// The whole pipeline advances together unless the output beat is being back-pressured.
module cla_adder_pipelined #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_cin,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_cout,
  output logic               out_ovf,
  output logic [WIDTH/4-1:0] out_P,
  output logic [WIDTH/4-1:0] out_G
);

  localparam int NB  = WIDTH / 4;   // number of 4-bit blocks
  localparam int BPS = NB / STAGES; // blocks resolved per carry stage

  // Index 0 is the capture stage; index STAGES doubles as the output register.
  logic [STAGES:0]  r_vld;
  logic [WIDTH-1:0] r_a   [0:STAGES];
  logic [WIDTH-1:0] r_b   [0:STAGES];
  logic [WIDTH-1:0] r_sum [0:STAGES];
  logic [NB-1:0]    r_p   [0:STAGES];
  logic [NB-1:0]    r_g   [0:STAGES];
  logic [STAGES:0]  r_c;
  logic             r_ovf;

  logic             w_stall;
  logic [WIDTH-1:0] w_sum_nx [1:STAGES];
  logic [NB-1:0]    w_p_nx   [1:STAGES];
  logic [NB-1:0]    w_g_nx   [1:STAGES];
  logic [STAGES:1]  w_c_nx;
  logic             w_ovf_nx;

  // Block propagate/generate from per-bit p = a ^ b and g = a & b. The result is {P, G}.
  function automatic logic [1:0] blk_pg(input logic [3:0] p, input logic [3:0] g);
    logic bp;
    logic bg;
    bp = &p;
    bg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {bp, bg};
  endfunction

  // 4-bit lookahead sum. The result is {carry into bit 3, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g,
                                      input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return {c[3], p ^ c};
  endfunction

  // A stall happens only when the output beat is held; then every stage freezes.
  assign w_stall   = r_vld[STAGES] & ~out_ready;
  assign in_ready  = ~w_stall;

  assign out_valid = r_vld[STAGES];
  assign out_sum   = r_sum[STAGES];
  assign out_cout  = r_c[STAGES];
  assign out_ovf   = r_ovf;
  assign out_P     = r_p[STAGES];
  assign out_G     = r_g[STAGES];

  // Per-stage carry resolution: block P/G first, then lookahead carries, then block sums.
  always_comb begin
    logic [WIDTH-1:0] w_sum;
    logic [NB-1:0]    w_p;
    logic [NB-1:0]    w_g;
    logic             w_c;
    logic [3:0]       w_bp;
    logic [3:0]       w_bg;
    logic [4:0]       w_blk;
    // NOTE: every value written here gets a default first, so no path can infer a latch.
    w_sum    = '0;
    w_p      = '0;
    w_g      = '0;
    w_c      = 1'b0;
    w_bp     = '0;
    w_bg     = '0;
    w_blk    = '0;
    w_ovf_nx = 1'b0;
    for (int k = 1; k <= STAGES; k++) begin
      w_sum = r_sum[k-1];
      w_p   = r_p[k-1];
      w_g   = r_g[k-1];
      w_c   = r_c[k-1];
      for (int j = (k - 1) * BPS; j < k * BPS; j++) begin
        w_bp = r_a[k-1][4*j +: 4] ^ r_b[k-1][4*j +: 4];
        w_bg = r_a[k-1][4*j +: 4] & r_b[k-1][4*j +: 4];
        {w_p[j], w_g[j]} = blk_pg(w_bp, w_bg);
      end
      for (int j = (k - 1) * BPS; j < k * BPS; j++) begin
        w_bp  = r_a[k-1][4*j +: 4] ^ r_b[k-1][4*j +: 4];
        w_bg  = r_a[k-1][4*j +: 4] & r_b[k-1][4*j +: 4];
        w_blk = cla4(w_bp, w_bg, w_c);
        w_sum[4*j +: 4] = w_blk[3:0];
        if (j == NB - 1) begin
          w_ovf_nx = w_blk[4] ^ (w_g[j] | (w_p[j] & w_c));
        end
        w_c = w_g[j] | (w_p[j] & w_c);
      end
      w_sum_nx[k] = w_sum;
      w_p_nx[k]   = w_p;
      w_g_nx[k]   = w_g;
      w_c_nx[k]   = w_c;
    end
  end

  // Pipeline registers: capture, carry stages, output. Data moves only with a valid beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: these arrays are pipeline flops, not a RAM. Clearing them keeps every output
      // defined after reset.
      r_vld <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int k = 0; k <= STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_p[k]   <= '0;
        r_g[k]   <= '0;
      end
    end else if (!w_stall) begin
      // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
      r_vld[0] <= in_valid;
      if (in_valid) begin
        r_a[0] <= in_a;
        r_b[0] <= in_sub ? ~in_b : in_b;
        r_c[0] <= in_sub | in_cin;
      end
      for (int k = 1; k <= STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_a[k]   <= r_a[k-1];
          r_b[k]   <= r_b[k-1];
          r_c[k]   <= w_c_nx[k];
          r_sum[k] <= w_sum_nx[k];
          r_p[k]   <= w_p_nx[k];
          r_g[k]   <= w_g_nx[k];
        end
      end
      if (r_vld[STAGES-1]) begin
        r_ovf <= w_ovf_nx;
      end
    end
  end

endmodule
